// File: rtl/signed_minmax_tracker.sv
// Streaming signed min/max/count tracker: consumes one packet of samples over valid/ready
// and holds the packet's signed minimum, maximum and saturating sample count until drained.
module signed_minmax_tracker #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_min,
    output logic [N-1:0]  out_max,
    output logic [CW-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [N-1:0]   min_d;
    logic [N-1:0]   max_d;
    logic [CW-1:0]  count_d;
    logic           accept_c;
    logic           lt_min_c;
    logic           lt_max_c;

    // Plain N-bit adder; the comparator feeds it a and ~b with carry-in 1.
    function automatic logic [N-1:0] adder_n(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic         cin);
        return a + b + N'(cin);
    endfunction

    // Signed a < b from the subtractor MSB, corrected when a - b overflows.
    function automatic logic signed_lt(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        logic [N-1:0] t;
        s = adder_n(a, ~b, 1'b1);
        t = s ^ ((s ^ a) & (a ^ b));
        return 1'(t >> (N - 1));
    endfunction

    assign lt_min_c = signed_lt(in_data, out_min);
    assign lt_max_c = signed_lt(out_max, in_data);

    assign in_ready = rst & (state != DONE);
    assign accept_c = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next values of the result registers.
    always_comb begin
        state_d = state;
        min_d   = out_min;
        max_d   = out_max;
        count_d = out_count;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    count_d = CW'(1);
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_c) begin
                    if (lt_min_c) begin
                        min_d = in_data;
                    end
                    if (lt_max_c) begin
                        max_d = in_data;
                    end
                    if (out_count != {CW{1'b1}}) begin
                        count_d = out_count + CW'(1);
                    end
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            out_min   <= min_d;
            out_max   <= max_d;
            out_count <= count_d;
            out_valid <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Scoreboard bench: two 8-bit trackers (CW=16 and CW=2) share one stimulus stream and are
// checked against a queue-based min/max/count reference model.
module tb_signed_minmax_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [7:0]  out_min_a, out_max_a, out_min_b, out_max_b;
    logic [15:0] out_count_a;
    logic [1:0]  out_count_b;

    int errors = 0;
    int checks = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        int mn;
        int mx;
        int c16;
        int c2;
    } exp_t;

    exp_t exp_q[$];
    bit   m_first = 1'b1;
    int   m_min, m_max, m_cnt;

    signed_minmax_tracker #(.N(8), .CW(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_min(out_min_a), .out_max(out_max_a),
        .out_count(out_count_a)
    );

    signed_minmax_tracker #(.N(8), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_min(out_min_b), .out_max(out_max_b),
        .out_count(out_count_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference model: min/max/count of the beats seen so far in the current packet.
    task automatic model_accept(input int d, input bit last);
        if (m_first) begin
            m_min = d;
            m_max = d;
            m_cnt = 1;
            m_first = 1'b0;
        end else begin
            if (d < m_min) m_min = d;
            if (d > m_max) m_max = d;
            m_cnt++;
        end
        if (last) begin
            exp_q.push_back('{m_min, m_max, sat(m_cnt, 65535), sat(m_cnt, 3)});
            m_first = 1'b1;
        end
    endtask

    // Present one beat (entered just after a rising edge) and hold it until accepted.
    task automatic send_beat(input int d, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = 8'(d);
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready_a) break;
            n++;
            if (n > 200) begin
                errors++;
                checks++;
                $display("FAIL accept_timeout: in_ready stayed %0d, expected 1", in_ready_a);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        chk("in_ready_b_match", longint'(in_ready_b), 1);
        @(posedge clk);
        model_accept(d, last);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, longint'(out_valid_a), 0);
        chk({tag, "_ready"}, longint'(in_ready_a), 0);
        chk({tag, "_min"},   longint'(out_min_a), 0);
        chk({tag, "_max"},   longint'(out_max_a), 0);
        chk({tag, "_count"}, longint'(out_count_a), 0);
        chk({tag, "_count_b"}, longint'(out_count_b), 0);
    endtask

    function automatic int rand_sample();
        int k;
        k = int'($urandom_range(0, 5));
        case (k)
            0:       return -128;
            1:       return 127;
            2:       return -1;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    // Monitor: each drained result is compared with the oldest expected packet.
    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid_a && out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_result: out_valid=1 with min=%0d, none expected",
                         $signed(out_min_a));
            end else begin
                e = exp_q.pop_front();
                chk("min_a",   longint'($signed(out_min_a)), longint'(e.mn));
                chk("max_a",   longint'($signed(out_max_a)), longint'(e.mx));
                chk("count_a", longint'(out_count_a), longint'(e.c16));
                chk("valid_b", longint'(out_valid_b), 1);
                chk("min_b",   longint'($signed(out_min_b)), longint'(e.mn));
                chk("max_b",   longint'($signed(out_max_b)), longint'(e.mx));
                chk("count_b", longint'(out_count_b), longint'(e.c2));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", longint'(in_ready_a), 1);
        chk("post_reset_valid", longint'(out_valid_a), 0);

        // Back-to-back packet spanning the full signed range.
        out_ready = 1'b1;
        send_beat(5, 0);
        send_beat(-3, 0);
        send_beat(127, 0);
        send_beat(-128, 1);
        @(negedge clk);
        chk("latency_valid", longint'(out_valid_a), 1);
        chk("done_ready", longint'(in_ready_a), 0);
        @(negedge clk);
        chk("drained_valid", longint'(out_valid_a), 0);
        chk("drained_ready", longint'(in_ready_a), 1);
        @(posedge clk);
        #1;

        // Overflow-prone comparison pairs, single beat, ties, saturation.
        send_beat(127, 0);
        send_beat(-128, 1);
        send_beat(-128, 0);
        send_beat(127, 1);
        send_beat(42, 1);
        send_beat(7, 0);
        send_beat(7, 0);
        send_beat(7, 1);
        for (int i = 1; i <= 5; i++) send_beat(i, i == 5);
        idle_cycles(3);

        // in_last without in_valid must not close the packet.
        send_beat(5, 0);
        in_last = 1'b1;
        idle_cycles(2);
        chk("stray_last_valid", longint'(out_valid_a), 0);
        in_last = 1'b0;
        send_beat(6, 1);
        idle_cycles(3);

        // Backpressure: result held, pending sample 99 not absorbed.
        out_ready = 1'b0;
        send_beat(10, 0);
        send_beat(-20, 1);
        in_valid = 1'b1;
        in_data  = 8'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", longint'(out_valid_a), 1);
            chk("bp_ready", longint'(in_ready_a), 0);
            chk("bp_min", longint'($signed(out_min_a)), -20);
            chk("bp_max", longint'($signed(out_max_a)), 10);
            chk("bp_count", longint'(out_count_a), 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(99, 1);
        idle_cycles(3);

        // Reset mid-packet discards it.
        send_beat(-10, 0);
        send_beat(20, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        exp_q.delete();
        m_first = 1'b1;
        @(negedge clk);
        chk("rst_hold_ready", longint'(in_ready_a), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_beat(3, 1);
        idle_cycles(3);

        // Reset while a result is held.
        out_ready = 1'b0;
        send_beat(-50, 0);
        send_beat(60, 1);
        @(negedge clk);
        chk("held_valid", longint'(out_valid_a), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_done");
        exp_q.delete();
        m_first = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Randomized packets, gaps and consumer backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(1, 12));
            for (int b = 0; b < len; b++) begin
                idle_cycles(int'($urandom_range(0, 2)));
                send_beat(rand_sample(), b == len - 1);
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        idle_cycles(2);
        chk("results_outstanding", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
